// File: rtl/peg_l2_tx_seq.sv
// Layer-2 transmit sequencer: wraps client bytes in preamble/SFD, pads short
// frames to the minimum length, and enforces the inter-frame gap on the RS side.
//
// state | meaning
// IDLE  | waiting for a client sop; non-sop bytes are drained and dropped
// PRE   | sending the 7 preamble bytes, LSB byte first
// SFD   | sending the start-frame delimiter
// DATA  | passing client bytes straight through to the RS layer
// PAD   | sending zero bytes until the minimum frame length is reached
// IFG   | holding the line idle for the inter-frame gap
module peg_l2_tx_seq #(
  parameter logic [55:0] PREAMBLE_VALUE  = 56'h55555555555555,
  parameter logic [7:0]  SFD_VALUE       = 8'hD5,
  parameter int          MIN_FRAME_BYTES = 60,
  parameter int          IFG_BYTES       = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic       pkt_sop,
  input  logic       pkt_eop,
  input  logic [7:0] pkt_data,
  output logic       pkt_ready,
  input  logic       rs_ready,
  output logic       rs_tx_en,
  output logic [7:0] rs_tx_data,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_SFD  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_PAD  = 3'd4;
  localparam logic [2:0] S_IFG  = 3'd5;

  localparam logic [10:0] MIN_B    = 11'(MIN_FRAME_BYTES);
  localparam logic [15:0] IFG_LOAD = 16'(IFG_BYTES - 1);

  logic [2:0]  state;
  logic [2:0]  pre_cnt;
  logic [2:0]  pre_idx;
  logic [10:0] byte_cnt;
  logic [10:0] cnt_inc;
  logic [15:0] ifg_cnt;

  // Byte count saturates so oversize frames cannot wrap back under the pad limit.
  assign cnt_inc = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
  assign pre_idx = 3'd6 - pre_cnt;
  assign busy    = (state != S_IDLE);

  always_comb begin
    pkt_ready  = 1'b0;
    rs_tx_en   = 1'b0;
    rs_tx_data = 8'h00;
    case (state)
      S_IDLE: pkt_ready = pkt_valid && !pkt_sop;
      S_PRE: begin
        rs_tx_en   = 1'b1;
        rs_tx_data = PREAMBLE_VALUE[{pre_idx, 3'b000} +: 8];
      end
      S_SFD: begin
        rs_tx_en   = 1'b1;
        rs_tx_data = SFD_VALUE;
      end
      S_DATA: begin
        pkt_ready  = rs_ready;
        rs_tx_en   = pkt_valid;
        rs_tx_data = pkt_data;
      end
      S_PAD: rs_tx_en = 1'b1;
      default: ;
    endcase
    // Keep the client from seeing a handshake while reset is asserted.
    if (rst) pkt_ready = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pre_cnt    <= 3'd0;
      byte_cnt   <= 11'd0;
      ifg_cnt    <= 16'd0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pkt_valid && pkt_sop) begin
            state   <= S_PRE;
            pre_cnt <= 3'd6;
          end
        end
        S_PRE: begin
          if (rs_ready) begin
            if (pre_cnt == 3'd0) state <= S_SFD;
            else                 pre_cnt <= pre_cnt - 3'd1;
          end
        end
        S_SFD: begin
          if (rs_ready) begin
            state    <= S_DATA;
            byte_cnt <= 11'd0;
          end
        end
        S_DATA: begin
          if (rs_ready) begin
            if (pkt_valid) begin
              byte_cnt <= cnt_inc;
              if (pkt_eop) begin
                if (cnt_inc < MIN_B) begin
                  state <= S_PAD;
                end else begin
                  state      <= S_IFG;
                  ifg_cnt    <= IFG_LOAD;
                  frame_done <= 1'b1;
                end
              end
            end else begin
              // Client starved an RS slot: the frame is abandoned.
              state    <= S_IFG;
              ifg_cnt  <= IFG_LOAD;
              underrun <= 1'b1;
            end
          end
        end
        S_PAD: begin
          if (rs_ready) begin
            byte_cnt <= cnt_inc;
            if (cnt_inc >= MIN_B) begin
              state      <= S_IFG;
              ifg_cnt    <= IFG_LOAD;
              frame_done <= 1'b1;
            end
          end
        end
        S_IFG: begin
          if (rs_ready) begin
            if (ifg_cnt == 16'd0) state <= S_IDLE;
            else                  ifg_cnt <= ifg_cnt - 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
